posta_accum_quant: RTL and testbench

Downstream consumer of the deconvolution post-transform stage. It takes the 4x4 signed ACC_W output patches, one per input-channel tile, and accumulates them across channel tiles until a tile marked last arrives. It then requantizes the sum to DATA_W with a runtime right shift, rounding and saturation. Finished patches go into a small show-ahead output FIFO with a valid/ready handshake toward the output-buffer writer.

---
 rtl/posta_accum_quant.sv | 164 ++++++++++++++++
 tb/tb_posta_accum_quant.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/posta_accum_quant.sv
// Accumulates 4x4 post-transform patches across channel tiles, requantizes the sum to DATA_W
// (round half up, saturate) and queues results in a show-ahead FIFO. Optional macro: POSTA_RELU_EN.
module posta_accum_quant #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = DATA_W + 8,
    parameter int SUM_W      = ACC_W + 8,
    parameter int SHIFT_W    = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic signed [ACC_W-1:0]  patch_in [0:3][0:3],
    input  logic                     last_in,
    input  logic [SHIFT_W-1:0]       shift,
    output logic                     in_ready,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic signed [DATA_W-1:0] patch_out [0:3][0:3],
    output logic                     sat_out,
    output logic                     ovf_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]       DEPTH_CMP = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [SHIFT_W-1:0]   SHIFT_ONE = SHIFT_W'(1);
    localparam logic signed [SUM_W:0] RND_ONE  = (SUM_W + 1)'(1);
    localparam logic signed [SUM_W:0] Q_MAX = {{(SUM_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SUM_W:0] Q_MIN = {{(SUM_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [SUM_W-1:0]  acc_r [0:3][0:3];
    logic signed [DATA_W-1:0] fifo_data_r [0:FIFO_DEPTH-1][0:3][0:3];
    logic [FIFO_DEPTH-1:0]    fifo_sat_r;
    logic [CNT_W-1:0]         fifo_cnt_r;
    logic                     first_r;
    logic                     pend_r;
    logic                     ovf_err_r;
    logic [SHIFT_W-1:0]       shift_q_r;
    logic [DATA_W:0]          q_full_s [0:3][0:3];
    logic                     sat_s;
    logic                     acc_fire_s;
    logic                     push_s;
    logic                     pop_s;
    logic [CNT_W-1:0]         wr_idx_s;

    // Returns {sat, value}: rounded arithmetic right shift followed by clamping to DATA_W.
    function automatic logic [DATA_W:0] quantize(input logic signed [SUM_W-1:0] a,
                                                 input logic [SHIFT_W-1:0] s);
        logic signed [SUM_W:0]  ext;
        logic signed [SUM_W:0]  r;
        logic signed [DATA_W-1:0] v;
        logic                   sat;
        ext = {a[SUM_W-1], a};
        if (s != '0) begin
            r = (ext + (RND_ONE << (s - SHIFT_ONE))) >>> s;
        end else begin
            r = ext;
        end
        if (r > Q_MAX) begin
            v   = Q_MAX[DATA_W-1:0];
            sat = 1'b1;
`ifdef POSTA_RELU_EN
        end else if (r[SUM_W]) begin
            v   = '0;
            sat = 1'b0;
`else
        end else if (r < Q_MIN) begin
            v   = Q_MIN[DATA_W-1:0];
            sat = 1'b1;
`endif
        end else begin
            v   = r[DATA_W-1:0];
            sat = 1'b0;
        end
        return {sat, v};
    endfunction

    assign in_ready   = ({1'b0, fifo_cnt_r} + {{CNT_W{1'b0}}, pend_r}) < DEPTH_CMP;
    assign acc_fire_s = valid_in && in_ready;
    assign valid_out  = (fifo_cnt_r != '0);
    assign pop_s      = valid_out && ready_out;
    assign push_s     = pend_r;
    assign wr_idx_s   = pop_s ? (fifo_cnt_r - CNT_ONE) : fifo_cnt_r;
    assign patch_out  = fifo_data_r[0];
    assign sat_out    = fifo_sat_r[0];
    assign ovf_err    = ovf_err_r;

    // Requantize the finished accumulator; only consumed on the cycle pend_r is set.
    always_comb begin
        sat_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                q_full_s[i][j] = quantize(acc_r[i][j], shift_q_r);
                sat_s          = sat_s | q_full_s[i][j][DATA_W];
            end
        end
    end

    // Channel-tile accumulation, end-of-accumulation capture and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    acc_r[i][j] <= '0;
                end
            end
            first_r   <= 1'b1;
            pend_r    <= 1'b0;
            shift_q_r <= '0;
            ovf_err_r <= 1'b0;
        end else begin
            if (acc_fire_s) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        acc_r[i][j] <= (first_r ? '0 : acc_r[i][j]) +
                            {{(SUM_W - ACC_W){patch_in[i][j][ACC_W-1]}}, patch_in[i][j]};
                    end
                end
                first_r <= last_in;
            end
            if (acc_fire_s && last_in) begin
                shift_q_r <= shift;
            end
            pend_r <= acc_fire_s && last_in;
            if (valid_in && !in_ready) begin
                ovf_err_r <= 1'b1;
            end
        end
    end

    // Show-ahead FIFO kept as a shift register so the head always sits in entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        fifo_data_r[k][i][j] <= '0;
                    end
                end
            end
            fifo_sat_r <= '0;
            fifo_cnt_r <= '0;
        end else begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (push_s && (CNT_W'(k) == wr_idx_s)) begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            fifo_data_r[k][i][j] <= q_full_s[i][j][DATA_W-1:0];
                        end
                    end
                    fifo_sat_r[k] <= sat_s;
                end else if (pop_s && (k < FIFO_DEPTH - 1)) begin
                    fifo_data_r[k] <= fifo_data_r[(k < FIFO_DEPTH - 1) ? k + 1 : k];
                    fifo_sat_r[k]  <= fifo_sat_r[(k < FIFO_DEPTH - 1) ? k + 1 : k];
                end
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end
endmodule

// File: tb/tb_posta_accum_quant.sv
// Self-checking bench for posta_accum_quant: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_posta_accum_quant;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = DATA_W + 8;
    localparam int SHIFT_W = 5;
    localparam int DEPTH   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic signed [ACC_W-1:0] patch_in [0:3][0:3];
    logic last_in = 1'b0;
    logic [SHIFT_W-1:0] shift = '0;
    logic in_ready;
    logic valid_out;
    logic ready_out = 1'b1;
    logic signed [DATA_W-1:0] patch_out [0:3][0:3];
    logic sat_out;
    logic ovf_err;

    posta_accum_quant dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .patch_in(patch_in),
        .last_in(last_in), .shift(shift), .in_ready(in_ready), .valid_out(valid_out),
        .ready_out(ready_out), .patch_out(patch_out), .sat_out(sat_out), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][15:0] v;
        logic              sat;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   dut_pops = 0;
    int   macc [16];
    bit   mfirst = 1'b1;
    bit   mpend = 1'b0;
    int   mshift = 0;
    bit   movf = 1'b0;
    exp_t mq [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec arithmetic: round half up by adding 2^(s-1) then floor-divide by 2^s, then clamp.
    task automatic mquant(input int a, input int s, output int v, output bit sat);
        longint r;
        r = (s > 0) ? ((longint'(a) + (longint'(1) << (s - 1))) >>> s) : longint'(a);
        sat = 1'b0;
        if (r > 32767) begin
            v = 32767; sat = 1'b1;
`ifdef POSTA_RELU_EN
        end else if (r < 0) begin
            v = 0;
`else
        end else if (r < -32768) begin
            v = -32768; sat = 1'b1;
`endif
        end else begin
            v = int'(r);
        end
    endtask

    task automatic model_step();
        bit   rdy;
        bit   fire;
        int   v;
        bit   s;
        exp_t e;
        rdy  = (mq.size() + int'(mpend)) < DEPTH;
        fire = valid_in && rdy;
        if (valid_in && !rdy) movf = 1'b1;
        if ((mq.size() != 0) && ready_out) void'(mq.pop_front());
        if (mpend) begin
            e = '0;
            for (int k = 0; k < 16; k++) begin
                mquant(macc[k], mshift, v, s);
                e.v[k] = 16'(v);
                e.sat  = e.sat | s;
            end
            mq.push_back(e);
        end
        mpend = fire && last_in;
        if (fire) begin
            for (int k = 0; k < 16; k++) begin
                macc[k] = (mfirst ? 0 : macc[k]) + int'(patch_in[k / 4][k % 4]);
            end
            if (last_in) mshift = int'(shift);
            mfirst = last_in;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) macc[k] = 0;
            mfirst = 1'b1; mpend = 1'b0; mshift = 0; movf = 1'b0;
            mq.delete();
        end else begin
            model_step();
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int   hb;
        exp_t e;
        chk("in_ready", in_ready, ((mq.size() + int'(mpend)) < DEPTH) ? 1 : 0);
        chk("valid_out", valid_out, (mq.size() != 0) ? 1 : 0);
        chk("ovf_err", ovf_err, movf);
        if (mq.size() != 0 && valid_out) begin
            e  = mq[0];
            hb = 0;
            for (int k = 0; k < 16; k++) begin
                if (int'(patch_out[k / 4][k % 4]) != int'($signed(e.v[k]))) hb = k;
            end
            chk("head_data", patch_out[hb / 4][hb % 4], $signed(e.v[hb]));
            chk("head_sat", sat_out, e.sat);
        end
        if (valid_out && ready_out) dut_pops++;
    end

    task automatic set_all(input int val);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                patch_in[i][j] = ACC_W'(val);
    endtask

    task automatic send(input bit l, input int sh, input int val);
        valid_in = 1'b1; last_in = l; shift = SHIFT_W'(sh); set_all(val);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic signed [ACC_W-1:0] rnd_elem();
        if ($urandom_range(0, 3) == 0) return ACC_W'($urandom);
        return ACC_W'(int'($urandom_range(0, 4000)) - 2000);
    endfunction

    initial begin
        int  v;
        bit  s;
        int  sent;
        int  pops0;
        bit  drove;
        set_all(0);
        // Pin the reference model with hand-computed values.
        mquant(12, 3, v, s);          chk("pin_rnd_12", v, 2);
        mquant(-12, 3, v, s);         chk("pin_rnd_m12", v, -1);
        mquant(11, 3, v, s);          chk("pin_rnd_11", v, 1);
        mquant(1 << 20, 0, v, s);     chk("pin_sat_hi", v, 32767); chk("pin_sat_hi_flag", s, 1);
        mquant(-(1 << 20), 0, v, s);
`ifdef POSTA_RELU_EN
        chk("pin_sat_lo", v, 0);
`else
        chk("pin_sat_lo", v, -32768);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1); chk("rst_valid", valid_out, 0);
        chk("rst_patch", patch_out[3][3], 0); chk("rst_sat", sat_out, 0); chk("rst_ovf", ovf_err, 0);
        rst_n = 1'b1;
        idle(1);

        // Single tile, two-cycle latency.
        ready_out = 1'b1;
        send(1'b1, 0, 100);
        chk("t1_not_yet", valid_out, 0);
        idle(1);
        chk("t1_valid", valid_out, 1); chk("t1_data", patch_out[1][2], 100); chk("t1_sat", sat_out, 0);

        // Three-tile accumulation with shift, then a fresh accumulation.
        idle(1);
        send(1'b0, 0, 1000); send(1'b0, 0, 2000); send(1'b1, 2, -500);
        idle(1);
        chk("t2_625", patch_out[3][0], 625);
        send(1'b1, 0, 5);
        idle(1);
        chk("t2_restart", patch_out[2][2], 5);

        // Rounding and saturation patches.
        idle(1);
        set_all(0); patch_in[0][0] = 24'sd12; patch_in[0][1] = -24'sd12; patch_in[0][2] = 24'sd11;
        valid_in = 1'b1; last_in = 1'b1; shift = 5'd3;
        @(posedge clk); #1;
        idle(1);
        chk("rnd_12", patch_out[0][0], 2); chk("rnd_m12", patch_out[0][1], -1);
        chk("rnd_11", patch_out[0][2], 1); chk("rnd_sat", sat_out, 0);
        set_all(0); patch_in[1][0] = 24'sd1048576; patch_in[1][1] = -24'sd1048576;
        valid_in = 1'b1; last_in = 1'b1; shift = 5'd0;
        @(posedge clk); #1;
        idle(1);
        chk("sat_hi", patch_out[1][0], 32767); chk("sat_flag", sat_out, 1);
`ifdef POSTA_RELU_EN
        chk("sat_lo", patch_out[1][1], 0);
`else
        chk("sat_lo", patch_out[1][1], -32768);
`endif

        // Backpressure: two accepted, third dropped, head held, ordered drain.
        idle(2);
        ready_out = 1'b0;
        send(1'b1, 0, 1); send(1'b1, 0, 2);
        chk("bp_in_ready_low", in_ready, 0);
        send(1'b1, 0, 3);
        chk("bp_ovf", ovf_err, 1);
        idle(3);
        chk("bp_hold_valid", valid_out, 1); chk("bp_hold_head", patch_out[0][0], 1);
        ready_out = 1'b1;
        idle(1);
        chk("bp_drain2", patch_out[0][0], 2);
        idle(1);
        chk("bp_empty", valid_out, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 300; c++) begin
            valid_in  = ($urandom_range(0, 9) < 7);
            last_in   = ($urandom_range(0, 9) < 3);
            shift     = SHIFT_W'($urandom_range(0, 20));
            ready_out = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    patch_in[i][j] = rnd_elem();
            @(posedge clk); #1;
        end
        ready_out = 1'b1;
        idle(6);

        // Reset in the middle of an accumulation.
        send(1'b0, 0, 50); send(1'b0, 0, 60);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", in_ready, 1); chk("mrst_valid", valid_out, 0);
        chk("mrst_patch", patch_out[0][0], 0); chk("mrst_sat", sat_out, 0); chk("mrst_ovf", ovf_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send(1'b1, 0, 7);
        idle(1);
        chk("mrst_seven", patch_out[2][1], 7);
        idle(2);

        // Continuous single-tile stream honouring in_ready.
        sent = 0;
        pops0 = dut_pops;
        for (int c = 0; c < 100 && sent < 20; c++) begin
            drove = in_ready;
            valid_in = drove; last_in = 1'b1; shift = SHIFT_W'($urandom_range(0, 8));
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    patch_in[i][j] = rnd_elem();
            @(posedge clk); #1;
            if (drove) sent++;
        end
        idle(6);
        chk("stream_sent", sent, 20);
        chk("stream_pops", dut_pops - pops0, 20);
        chk("stream_no_drop", ovf_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
